// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Purpose  : Shared definitions for the multi-cycle control unit: FSM state
//            encoding, RV32I opcode constants, pcSelect / memToReg / access
//            size encodings, the control-word structure and the decode
//            helpers that turn (state, instruction fields) into controls.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_IALU   = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [1:0] c_PCSEL_PLUS4 = 2'b00;
  localparam logic [1:0] c_PCSEL_IMM   = 2'b01;
  localparam logic [1:0] c_PCSEL_ALU   = 2'b10;

  localparam logic [1:0] c_WB_ALU  = 2'b00;
  localparam logic [1:0] c_WB_RAM  = 2'b01;
  localparam logic [1:0] c_WB_LINK = 2'b10;
  localparam logic [1:0] c_WB_IMM  = 2'b11;

  // funct3[1:0] of loads/stores
  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_BAD  = 2'b11;

  // brSel marks the branch retire cycle; the comparator result is only
  // valid in that same cycle, so it is merged into pcSelect combinationally.
  typedef struct packed {
    logic       pcEn;
    logic [1:0] pcSelect;
    logic       regWrite;
    logic       aluSrc;
    logic       ramRdEn;
    logic       ramWrEn;
    logic       isByte;
    logic       isHalf;
    logic       isWord;
    logic [1:0] memToReg;
    logic       brSel;
  } ctrl_t;

  // State that follows DECODE for a given instruction.
  function automatic state_t dispatch(input logic [6:0] op, input logic [2:0] f3);
    state_t ns;
    case (op)
      c_OP_RTYPE, c_OP_IALU, c_OP_BRANCH, c_OP_JALR: ns = S_EXEC;
      c_OP_LOAD, c_OP_STORE: ns = (f3[1:0] == c_SIZE_BAD) ? S_HALT : S_EXEC;
      c_OP_LUI, c_OP_JAL:    ns = S_WB;
      default:               ns = S_HALT;
    endcase
    return ns;
  endfunction

  // Control word to present while in 'state'. memFirst/memLast flag the
  // first and last cycle of a MEM phase (both set when it lasts one cycle).
  function automatic ctrl_t decodeCtrl(
    input state_t     state,
    input logic [6:0] op,
    input logic [2:0] f3,
    input logic       memFirst,
    input logic       memLast
  );
    ctrl_t c;
    logic  isLoad;
    logic  isStore;
    c       = '0;
    isLoad  = (op == c_OP_LOAD);
    isStore = (op == c_OP_STORE);
    case (state)
      S_EXEC: begin
        c.aluSrc = (op == c_OP_IALU) || isLoad || isStore || (op == c_OP_JALR);
        if (op == c_OP_BRANCH) begin
          c.pcEn     = 1'b1;
          c.pcSelect = c_PCSEL_PLUS4;
          c.brSel    = 1'b1;
        end
      end
      S_MEM: begin
        c.aluSrc  = 1'b1;
        c.isByte  = (f3[1:0] == c_SIZE_BYTE);
        c.isHalf  = (f3[1:0] == c_SIZE_HALF);
        c.isWord  = (f3[1:0] == c_SIZE_WORD);
        c.ramRdEn = isLoad;
        c.ramWrEn = isStore && memFirst;
        c.pcEn    = isStore && memLast;
      end
      S_WB: begin
        c.regWrite = 1'b1;
        c.pcEn     = 1'b1;
        c.aluSrc   = (op == c_OP_IALU) || (op == c_OP_JALR);
        case (op)
          c_OP_LOAD:           c.memToReg = c_WB_RAM;
          c_OP_JAL, c_OP_JALR: c.memToReg = c_WB_LINK;
          c_OP_LUI:            c.memToReg = c_WB_IMM;
          default:             c.memToReg = c_WB_ALU;
        endcase
        case (op)
          c_OP_JAL:  c.pcSelect = c_PCSEL_IMM;
          c_OP_JALR: c.pcSelect = c_PCSEL_ALU;
          default:   c.pcSelect = c_PCSEL_PLUS4;
        endcase
        // Loads keep the RAM read path steady while the data is written back.
        if (isLoad) begin
          c.ramRdEn = 1'b1;
          c.isByte  = (f3[1:0] == c_SIZE_BYTE);
          c.isHalf  = (f3[1:0] == c_SIZE_HALF);
          c.isWord  = (f3[1:0] == c_SIZE_WORD);
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_counter
// Purpose  : Loadable down-counter timing the MEM phase. Load has priority
//            over enable; counting stops at zero.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_load            - load i_loadValue
//            i_loadValue       - value loaded on i_load
//            i_en              - decrement while non-zero
//            o_count           - current count
//            o_zero            - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Multi-cycle FSM sequencing an RV32I-subset datapath through
//            FETCH / DECODE / EXEC / MEM / WB, with a sticky HALT for
//            unsupported encodings and a retired-instruction counter.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            opcode, funct3    - instruction fields (valid in DECODE)
//            brTaken           - branch comparator result
//            pcEn, pcSelect    - PC update strobe and next-PC source
//            regWrite, aluSrc  - register write enable, ALU operand-2 source
//            ramRdEn, ramWrEn  - data RAM read / write enables
//            isByte/Half/Word  - data RAM access size
//            memToReg          - writeback source
//            halted            - sticky illegal-instruction flag
//            instret           - retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              brTaken,
  output logic              pcEn,
  output logic [1:0]        pcSelect,
  output logic              regWrite,
  output logic              aluSrc,
  output logic              ramRdEn,
  output logic              ramWrEn,
  output logic              isByte,
  output logic              isHalf,
  output logic              isWord,
  output logic [1:0]        memToReg,
  output logic              halted,
  output logic [DWIDTH-1:0] instret
);

  localparam int               c_CNT_W    = 4;
  localparam logic [c_CNT_W-1:0] c_MEM_WAIT = c_CNT_W'(MEM_WAIT);

  state_t              r_state;
  state_t              w_nextState;
  logic [6:0]          r_opcode;
  logic [2:0]          r_funct3;
  logic [6:0]          w_nextOpcode;
  logic [2:0]          w_nextFunct3;
  ctrl_t               r_ctrl;
  ctrl_t               w_ctrl;
  logic                r_halted;
  logic [DWIDTH-1:0]   r_instret;

  logic [c_CNT_W-1:0]  w_count;
  logic                w_cntZero;
  logic                w_cntLoad;
  logic                w_cntEn;
  logic                w_nextMemFirst;
  logic                w_nextMemLast;

  // Instruction fields are captured at the end of DECODE and held until the
  // next DECODE; the control word for the following state needs them early.
  assign w_nextOpcode = (r_state == S_DECODE) ? opcode : r_opcode;
  assign w_nextFunct3 = (r_state == S_DECODE) ? funct3 : r_funct3;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: w_nextState = dispatch(opcode, funct3);
      S_EXEC: begin
        if ((r_opcode == c_OP_LOAD) || (r_opcode == c_OP_STORE)) begin
          w_nextState = S_MEM;
        end else if (r_opcode == c_OP_BRANCH) begin
          w_nextState = S_FETCH;
        end else begin
          w_nextState = S_WB;
        end
      end
      S_MEM: begin
        if (w_cntZero) begin
          w_nextState = (r_opcode == c_OP_LOAD) ? S_WB : S_FETCH;
        end
      end
      S_WB:     w_nextState = S_FETCH;
      S_HALT:   w_nextState = S_HALT;
      default:  w_nextState = S_HALT;
    endcase
  end

  assign w_cntLoad = (r_state == S_EXEC) && (w_nextState == S_MEM);
  assign w_cntEn   = (r_state == S_MEM);

  mem_wait_counter #(
    .WIDTH (c_CNT_W)
  ) u_memWaitCounter (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_cntLoad),
    .i_loadValue (c_MEM_WAIT),
    .i_en        (w_cntEn),
    .o_count     (w_count),
    .o_zero      (w_cntZero)
  );

  // First/last flags of the upcoming MEM cycle, derived from the count the
  // counter will hold after this edge.
  assign w_nextMemFirst = w_cntLoad;
  assign w_nextMemLast  = (w_nextState == S_MEM) &&
                          (w_cntLoad ? (c_MEM_WAIT == '0) : (w_count == c_CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_ctrl    <= '0;
      r_halted  <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state   <= w_nextState;
      r_opcode  <= w_nextOpcode;
      r_funct3  <= w_nextFunct3;
      r_ctrl    <= decodeCtrl(w_nextState, w_nextOpcode, w_nextFunct3,
                              w_nextMemFirst, w_nextMemLast);
      r_halted  <= r_halted | (w_nextState == S_HALT);
      if (r_ctrl.pcEn) begin
        r_instret <= r_instret + DWIDTH'(1);
      end
    end
  end

  // Controls are forced low while reset is held so the datapath sees no
  // stale strobe from an interrupted instruction.
  assign w_ctrl   = reset ? '0 : r_ctrl;

  assign pcEn     = w_ctrl.pcEn;
  assign pcSelect = w_ctrl.pcSelect | {1'b0, w_ctrl.brSel & brTaken};
  assign regWrite = w_ctrl.regWrite;
  assign aluSrc   = w_ctrl.aluSrc;
  assign ramRdEn  = w_ctrl.ramRdEn;
  assign ramWrEn  = w_ctrl.ramWrEn;
  assign isByte   = w_ctrl.isByte;
  assign isHalf   = w_ctrl.isHalf;
  assign isWord   = w_ctrl.isWord;
  assign memToReg = w_ctrl.memToReg;
  assign halted   = r_halted & ~reset;
  assign instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Self-checking bench for multicycle_control_unit (MEM_WAIT = 2).
//            Expected per-cycle controls come from the instruction's
//            position in its cycle sequence and the published latencies.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam int W = 2;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        brTaken = 1'b0;
  logic        pcEn, regWrite, aluSrc, ramRdEn, ramWrEn, isByte, isHalf, isWord, halted;
  logic [1:0]  pcSelect, memToReg;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelInstret = '0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.DWIDTH(32), .MEM_WAIT(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .brTaken(brTaken),
    .pcEn(pcEn), .pcSelect(pcSelect), .regWrite(regWrite), .aluSrc(aluSrc),
    .ramRdEn(ramRdEn), .ramWrEn(ramWrEn), .isByte(isByte), .isHalf(isHalf),
    .isWord(isWord), .memToReg(memToReg), .halted(halted), .instret(instret)
  );

  // {pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn, isByte, isHalf, isWord, memToReg, halted}
  wire logic [12:0] obs = {pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
                           isByte, isHalf, isWord, memToReg, halted};

  function automatic int lat(input logic [6:0] op);
    case (op)
      LD:           return 5 + W;
      ST:           return 4 + W;
      LUI, JAL, BR: return 3;
      default:      return 4;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = FETCH) of a legal instruction.
  function automatic logic [12:0] expCtrl(input logic [6:0] op, input logic [2:0] f3,
                                          input logic br, input int k);
    logic       e_pcEn, e_regW, e_alu, e_rd, e_wr;
    logic [1:0] e_pcSel, e_m2r;
    logic [2:0] e_sz, szSel;
    bit         isLd, isSt;
    int         last, m;
    e_pcEn = 0; e_regW = 0; e_alu = 0; e_rd = 0; e_wr = 0;
    e_pcSel = 0; e_m2r = 0; e_sz = 0;
    isLd = (op == LD);
    isSt = (op == ST);
    case (f3[1:0])
      2'd0:    szSel = 3'b100;
      2'd1:    szSel = 3'b010;
      default: szSel = 3'b001;
    endcase
    last = lat(op) - 1;
    if (k >= 2) begin
      if (op == BR) begin
        e_pcEn = 1; e_pcSel = br ? 2'b01 : 2'b00;
      end else if (k == last && !isSt) begin
        e_regW = 1; e_pcEn = 1;
        e_alu  = (op == IALU) || (op == JALR);
        e_m2r  = isLd ? 2'b01 : ((op == JAL) || (op == JALR)) ? 2'b10 : (op == LUI) ? 2'b11 : 2'b00;
        e_pcSel = (op == JAL) ? 2'b01 : (op == JALR) ? 2'b10 : 2'b00;
        if (isLd) begin e_rd = 1; e_sz = szSel; end
      end else if (k == 2) begin
        e_alu = (op == IALU) || isLd || isSt || (op == JALR);
      end else begin
        m = k - 3;
        e_alu = 1; e_sz = szSel; e_rd = isLd;
        e_wr = isSt && (m == 0);
        e_pcEn = isSt && (m == W);
      end
    end
    return {e_pcEn, e_pcSel, e_regW, e_alu, e_rd, e_wr, e_sz, e_m2r, 1'b0};
  endfunction

  // Starts and ends at a falling edge inside a FETCH cycle.
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                          input string tag, input int stopAt = 1000);
    logic [12:0] e;
    int n, pcCount;
    opcode = op; funct3 = f3; brTaken = br;
    n = lat(op);
    pcCount = 0;
    for (int k = 0; k < n && k < stopAt; k++) begin
      e = expCtrl(op, f3, br, k);
      checks++;
      assert (obs === e) else begin
        errors++; $error("FAIL ctrl %s cyc%0d observed=%b expected=%b", tag, k, obs, e);
      end
      checks++;
      assert (instret === modelInstret) else begin
        errors++; $error("FAIL instret %s cyc%0d observed=%0d expected=%0d", tag, k, instret, modelInstret);
      end
      checks++;
      assert ((regWrite & ramWrEn) === 1'b0 && (ramRdEn & ramWrEn) === 1'b0) else begin
        errors++; $error("FAIL exclusive %s cyc%0d observed=%b expected=no overlap", tag, k, obs);
      end
      if (pcEn === 1'b1) pcCount++;
      @(negedge clk);
      if (e[12]) modelInstret++;
    end
    if (stopAt >= n) begin
      checks++;
      assert (pcCount == 1) else begin
        errors++; $error("FAIL pcEnOnce %s observed=%0d expected=1", tag, pcCount);
      end
    end
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    assert (obs === 13'b0) else begin
      errors++; $error("FAIL rstCtrl %s observed=%b expected=0", tag, obs);
    end
    checks++;
    assert (instret === 32'd0) else begin
      errors++; $error("FAIL rstInstret %s observed=%0d expected=0", tag, instret);
    end
    reset = 1'b0;
    modelInstret = '0;
    #1;
    checks++;
    assert (obs === 13'b0) else begin
      errors++; $error("FAIL postRst %s observed=%b expected=0", tag, obs);
    end
  endtask

  task automatic runIllegal(input logic [6:0] op, input logic [2:0] f3, input string tag);
    opcode = op; funct3 = f3; brTaken = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      assert (obs === ((k < 2) ? 13'b0 : 13'b1)) else begin
        errors++; $error("FAIL halt %s cyc%0d observed=%b expected=%b", tag, k, obs,
                         (k < 2) ? 13'b0 : 13'b1);
      end
      checks++;
      assert (instret === modelInstret) else begin
        errors++; $error("FAIL haltInstret %s cyc%0d observed=%0d expected=%0d", tag, k, instret, modelInstret);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal [8];
    logic [6:0] op;
    logic [2:0] f3;
    legal = '{R, IALU, LD, ST, BR, JALR, LUI, JAL};

    doReset("init");

    runInstr(R,    3'b000, 1'b0, "rtype");
    runInstr(LD,   3'b010, 1'b0, "lw");
    runInstr(ST,   3'b000, 1'b0, "sb");
    runInstr(BR,   3'b000, 1'b1, "beqTaken");
    runInstr(BR,   3'b001, 1'b0, "bneNotTaken");
    runInstr(JAL,  3'b000, 1'b0, "jal");
    runInstr(JALR, 3'b000, 1'b1, "jalr");
    runInstr(IALU, 3'b111, 1'b1, "andi");
    runInstr(LUI,  3'b101, 1'b0, "lui");
    runInstr(LD,   3'b101, 1'b0, "lhu");
    runInstr(ST,   3'b010, 1'b1, "sw");

    for (int i = 0; i < 40; i++) begin
      op = legal[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      if ((op == LD || op == ST) && f3[1:0] == 2'b11) f3[1:0] = 2'($urandom_range(0, 2));
      runInstr(op, f3, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // reset in the third MEM cycle of a load
    runInstr(LD, 3'b100, 1'b0, "lbuMidMem", 5);
    doReset("midMem");
    runInstr(R, 3'b000, 1'b0, "afterMidMem");

    runIllegal(7'b1111111, 3'b000, "op7f");
    doReset("afterOp7f");
    runInstr(IALU, 3'b000, 1'b0, "afterHalt");
    runIllegal(LD, 3'b011, "ldBadSize");
    doReset("afterLdBad");
    runIllegal(ST, 3'b111, "stBadSize");
    doReset("afterStBad");
    runInstr(ST, 3'b001, 1'b0, "sh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
